// File: rtl/dmem_requester.sv
// MEM-stage initiator for data_memory: issues loads/stores, freezes the pipeline on stalled loads.
// Define DMEM_TIMEOUT_EN to add a watchdog that aborts loads stalled for TIMEOUT WAIT cycles.
module dmem_requester #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_read,
  input  logic              pipe_write,
  input  logic [DATA_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  output logic              pipe_err,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              stall
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req, bad, timeout;

  // Gating with rst_n keeps the combinational issue path quiet while reset is held.
  assign req = rst_n & (pipe_read | pipe_write);
  assign bad = req & ((pipe_addr[1:0] != 2'b00) | (pipe_read & pipe_write));

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cleared while idle, so every WAIT entry starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StWait && stall) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == StWait) && stall && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    pipe_stall = 1'b0;
    address    = addr_q;
    write_data = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bad) begin
          err_d = 1'b1;
        end else if (req && pipe_read) begin
          read       = 1'b1;
          pipe_stall = 1'b1;
          address    = pipe_addr;
          addr_d     = pipe_addr;
          state_d    = StWait;
        end else if (req) begin
          write      = 1'b1;
          address    = pipe_addr;
          write_data = pipe_wdata;
          addr_d     = pipe_addr;
          wdata_d    = pipe_wdata;
        end
      end
      StWait: begin
        read       = 1'b1;
        pipe_stall = 1'b1;
        if (timeout) begin
          rdata_d = DATA_W'(32'hDEADBEEF);
          err_d   = 1'b1;
          state_d = StDone;
        end else if (!stall) begin
          rdata_d = read_data;
          state_d = StDone;
        end
      end
      // Pipe inputs still carry the finished load here, so they are ignored.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign pipe_rdata = rdata_q;
  assign pipe_err   = err_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Directed bench for dmem_requester with a small word-addressed memory model.
module tb_dmem_requester;

  logic        clk;
  logic        rst_n;
  logic        pipe_read;
  logic        pipe_write;
  logic [31:0] pipe_addr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_rdata;
  logic        pipe_stall;
  logic        pipe_err;
  logic        write;
  logic        read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];

  dmem_requester #(
    .DATA_W (32),
    .TIMEOUT(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe_read (pipe_read),
    .pipe_write(pipe_write),
    .pipe_addr (pipe_addr),
    .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata),
    .pipe_stall(pipe_stall),
    .pipe_err  (pipe_err),
    .write     (write),
    .read      (read),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .stall     (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (write) mem[address[5:2]] <= write_data;
  end
  assign read_data = mem[address[5:2]];

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pipe_read  = r;
    pipe_write = w;
    pipe_addr  = a;
    pipe_wdata = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0;
    pipe_read = 1'b1; pipe_write = 1'b0; pipe_addr = 32'h0; pipe_wdata = 32'h0;
    #12;
    n_cmp++; if (pipe_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", pipe_rdata); end
    n_cmp++; if (pipe_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", pipe_err); end
    n_cmp++; if (read !== 1'b0 || write !== 1'b0) begin n_bad++; $display("FAIL rst_rw got %b%b want 00", read, write); end
    n_cmp++; if (address !== 32'h0 || write_data !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h/%h want 0/0", address, write_data); end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_store;
    drive(1'b0, 1'b1, 32'h0, 32'h4);
    #1;
    n_cmp++; if (write !== 1'b1 || read !== 1'b0) begin n_bad++; $display("FAIL st0_rw got %b%b want 01", read, write); end
    n_cmp++; if (address !== 32'h0 || write_data !== 32'h4) begin n_bad++; $display("FAIL st0_bus got %h/%h want 0/4", address, write_data); end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL st0_stall got %b want 0", pipe_stall); end
    drive(1'b0, 1'b1, 32'h4, 32'h8);
    #1;
    n_cmp++; if (write !== 1'b1 || address !== 32'h4 || write_data !== 32'h8) begin n_bad++; $display("FAIL st1_bus got %b %h/%h want 1 4/8", write, address, write_data); end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL st1_stall got %b want 0", pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (write !== 1'b0 || read !== 1'b0) begin n_bad++; $display("FAIL st_idle_rw got %b%b want 00", read, write); end
    n_cmp++; if (address !== 32'h4 || write_data !== 32'h8) begin n_bad++; $display("FAIL st_hold got %h/%h want 4/8", address, write_data); end
  endtask

  task automatic test_long_stall;
    int  cnt;
    bit  stable;
    cnt = 0; stable = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!pipe_stall) break;
      cnt++;
      if (read !== 1'b1 || address !== 32'h0) stable = 1'b0;
      @(negedge clk);
      if (i == 19) stall = 1'b0;
    end
    n_cmp++; if (cnt != 21) begin n_bad++; $display("FAIL ls_stall_cycles got %0d want 21", cnt); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL ls_stable got %b want 1", stable); end
    n_cmp++; if (pipe_rdata !== 32'h4) begin n_bad++; $display("FAIL ls_rdata got %h want 4", pipe_rdata); end
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL ls_done_read got %b want 0", read); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    stall = 1'b0;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    n_cmp++; if (read !== 1'b1 || address !== 32'h4 || pipe_stall !== 1'b1) begin n_bad++; $display("FAIL bb0_issue got %b %h %b want 1 4 1", read, address, pipe_stall); end
    @(negedge clk); #1;
    n_cmp++; if (read !== 1'b1 || pipe_stall !== 1'b1) begin n_bad++; $display("FAIL bb0_wait got %b%b want 11", read, pipe_stall); end
    @(negedge clk); #1;
    n_cmp++; if (pipe_rdata !== 32'h8) begin n_bad++; $display("FAIL bb0_rdata got %h want 8", pipe_rdata); end
    n_cmp++; if (read !== 1'b0 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL bb0_done got %b%b want 00", read, pipe_stall); end
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (read !== 1'b1 || address !== 32'h0) begin n_bad++; $display("FAIL bb1_issue got %b %h want 1 0", read, address); end
    @(negedge clk); #1;
    n_cmp++; if (pipe_rdata !== 32'h8) begin n_bad++; $display("FAIL bb1_hold got %h want 8", pipe_rdata); end
    @(negedge clk); #1;
    n_cmp++; if (pipe_rdata !== 32'h4 || read !== 1'b0) begin n_bad++; $display("FAIL bb1_done got %h %b want 4 0", pipe_rdata, read); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_errors;
    drive(1'b1, 1'b0, 32'h2, 32'h0);
    #1;
    n_cmp++; if (read !== 1'b0 || write !== 1'b0 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL mis_bus got %b%b%b want 000", read, write, pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (pipe_err !== 1'b1) begin n_bad++; $display("FAIL mis_err got %b want 1", pipe_err); end
    n_cmp++; if (pipe_rdata !== 32'h4) begin n_bad++; $display("FAIL mis_rdata got %h want 4", pipe_rdata); end
    @(negedge clk); #1;
    n_cmp++; if (pipe_err !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got %b want 0", pipe_err); end
    drive(1'b1, 1'b1, 32'h0, 32'h55);
    #1;
    n_cmp++; if (read !== 1'b0 || write !== 1'b0 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rw_bus got %b%b%b want 000", read, write, pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (pipe_err !== 1'b1) begin n_bad++; $display("FAIL rw_err got %b want 1", pipe_err); end
    @(negedge clk); #1;
    n_cmp++; if (pipe_err !== 1'b0) begin n_bad++; $display("FAIL rw_pulse got %b want 0", pipe_err); end
  endtask

  task automatic test_reset_mid_wait;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    stall = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (read !== 1'b0 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rmw_async got %b%b want 00", read, pipe_stall); end
    n_cmp++; if (pipe_rdata !== 32'h0) begin n_bad++; $display("FAIL rmw_rdata got %h want 0", pipe_rdata); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (pipe_rdata !== 32'h4 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rmw_reload got %h %b want 4 0", pipe_rdata, pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    cnt = 0;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!pipe_stall) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++; if (cnt != 65) begin n_bad++; $display("FAIL to_cycles got %0d want 65", cnt); end
    n_cmp++; if (pipe_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL to_rdata got %h want deadbeef", pipe_rdata); end
    n_cmp++; if (pipe_err !== 1'b1 || read !== 1'b0) begin n_bad++; $display("FAIL to_done got err %b read %b want 1 0", pipe_err, read); end
    stall = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (pipe_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse got %b want 0", pipe_err); end
  endtask
`else
  task automatic test_no_timeout;
    int  cnt;
    bit  err_seen;
    cnt = 0; err_seen = 1'b0;
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (pipe_stall) cnt++;
      if (pipe_err) err_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (cnt != 100) begin n_bad++; $display("FAIL nt_cycles got %0d want 100", cnt); end
    n_cmp++; if (err_seen) begin n_bad++; $display("FAIL nt_err got %b want 0", err_seen); end
    stall = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (pipe_rdata !== 32'h8 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL nt_done got %h %b want 8 0", pipe_rdata, pipe_stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_long_stall();
    test_back_to_back();
    test_errors();
    test_reset_mid_wait();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
